// File: rtl/dist_relax_ctrl_if.sv
// Request/response channel between the edge-scan sequencer (master) and
// the relaxation controller (slave): one relaxation per accepted start.
interface dist_relax_ctrl_if #(
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 16
) ();
  logic                   start;
  logic [INDEX_WIDTH-1:0] src_idx;
  logic [INDEX_WIDTH-1:0] dst_idx;
  logic [VALUE_WIDTH-1:0] weight;
  logic                   busy;
  logic                   done;
  logic                   updated;

  modport master (
    output start, src_idx, dst_idx, weight,
    input  busy, done, updated
  );

  modport slave (
    input  start, src_idx, dst_idx, weight,
    output busy, done, updated
  );
endinterface

// File: rtl/dist_relax_ctrl.sv
// Dijkstra edge relaxation initiator: dist[dst] = min(dist[dst], dist[src] + w)
// over the shared DistanceStore bus. Optional macro RELAX_STATS_EN adds update_count.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif

module dist_relax_ctrl #(
  parameter int MAX_NODES    = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH  = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH  = `DEFAULT_VALUE_WIDTH,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  dist_relax_ctrl_if.slave       req,
  output logic                   store_set_en,
  output logic [INDEX_WIDTH-1:0] store_index,
  inout  wire  [VALUE_WIDTH-1:0] store_value
`ifdef RELAX_STATS_EN
  ,
  output logic [15:0]            update_count
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SET_U = 3'd1;
  localparam logic [2:0] CAP_U = 3'd2;
  localparam logic [2:0] SET_V = 3'd3;
  localparam logic [2:0] CAP_V = 3'd4;
  localparam logic [2:0] EVAL  = 3'd5;
  localparam logic [2:0] WRITE = 3'd6;
  localparam logic [2:0] FIN   = 3'd7;

  localparam logic [VALUE_WIDTH-1:0] INFINITY = {VALUE_WIDTH{1'b1}};
  localparam int                     WC_W     = $clog2(WRITE_CYCLES + 1);
  localparam logic [WC_W-1:0]        WC_LAST  = WC_W'(WRITE_CYCLES - 1);

  if (MAX_NODES > (1 << INDEX_WIDTH)) begin : g_bad_cfg
    $error("MAX_NODES does not fit in INDEX_WIDTH bits");
  end

  logic [2:0]             state;
  logic [INDEX_WIDTH-1:0] dst_q;
  logic [VALUE_WIDTH-1:0] w_q;
  logic [VALUE_WIDTH-1:0] du_q;
  logic [VALUE_WIDTH-1:0] dv_q;
  logic [VALUE_WIDTH-1:0] sum_q;
  logic                   improve_q;
  logic [WC_W-1:0]        wcnt;

  // The extra carry bit lets a wrapped sum still compare as too large.
  logic [VALUE_WIDTH:0] sum_c;
  logic                 improve_c;
  assign sum_c     = {1'b0, du_q} + {1'b0, w_q};
  assign improve_c = (du_q != INFINITY) && (sum_c < {1'b0, INFINITY})
                     && (sum_c < {1'b0, dv_q});

  assign store_value = store_set_en ? sum_q : {VALUE_WIDTH{1'bz}};

  assign req.busy    = (state != IDLE);
  assign req.done    = (state == FIN);
  assign req.updated = (state == FIN) && improve_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      store_set_en <= 1'b0;
      store_index  <= '0;
      dst_q        <= '0;
      w_q          <= '0;
      du_q         <= '0;
      dv_q         <= '0;
      sum_q        <= '0;
      improve_q    <= 1'b0;
      wcnt         <= '0;
    end else begin
      case (state)
        IDLE: if (req.start) begin
          store_index <= req.src_idx;
          dst_q       <= req.dst_idx;
          w_q         <= req.weight;
          state       <= SET_U;
        end
        SET_U: state <= CAP_U;
        CAP_U: begin
          du_q        <= store_value;
          store_index <= dst_q;
          state       <= SET_V;
        end
        SET_V: state <= CAP_V;
        CAP_V: begin
          dv_q  <= store_value;
          state <= EVAL;
        end
        EVAL: begin
          sum_q     <= sum_c[VALUE_WIDTH-1:0];
          improve_q <= improve_c;
          if (improve_c) begin
            store_set_en <= 1'b1;
            wcnt         <= '0;
            state        <= WRITE;
          end else begin
            state <= FIN;
          end
        end
        WRITE: begin
          if (wcnt == WC_LAST) begin
            store_set_en <= 1'b0;
            state        <= FIN;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RELAX_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      update_count <= '0;
    end else if ((state == FIN) && improve_q && (update_count != 16'hFFFF)) begin
      update_count <= update_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dist_relax_ctrl.sv
// Self-checking bench for dist_relax_ctrl: DistanceStore model on the bus,
// directed scenarios, then randomized relaxations against a reference array.
module tb_dist_relax_ctrl;
  localparam int NODES = 16;
  localparam int IW    = 4;
  localparam int VW    = 8;
  localparam int WC    = 2;
  localparam int INF   = (1 << VW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dist_relax_ctrl_if #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) req ();

  logic          store_set_en;
  logic [IW-1:0] store_index;
  wire  [VW-1:0] store_value;
`ifdef RELAX_STATS_EN
  logic [15:0]   update_count;
`endif

  dist_relax_ctrl #(
    .MAX_NODES(NODES), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .WRITE_CYCLES(WC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .store_set_en (store_set_en),
    .store_index  (store_index),
    .store_value  (store_value)
`ifdef RELAX_STATS_EN
    ,
    .update_count (update_count)
`endif
  );

  // DistanceStore model: read data one cycle after the index, writes on set_en.
  logic [VW-1:0] mem [NODES];
  logic [VW-1:0] rd_q;
  logic          clr_req = 1'b0;
  logic          pre_req = 1'b0;
  logic [IW-1:0] pre_idx = '0;
  logic [VW-1:0] pre_val = '0;

  always @(posedge clock) begin
    rd_q <= mem[store_index];
    if (clr_req) begin
      for (int i = 0; i < NODES; i++) mem[i] <= (i == 0) ? {VW{1'b0}} : {VW{1'b1}};
    end else if (pre_req) begin
      mem[pre_idx] <= pre_val;
    end else if (store_set_en) begin
      mem[store_index] <= store_value;
    end
  end
  assign store_value = store_set_en ? {VW{1'bz}} : rd_q;

  int ref_dist [NODES];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_store();
    @(negedge clock);
    clr_req = 1'b1;
    @(negedge clock);
    clr_req = 1'b0;
    for (int i = 0; i < NODES; i++) ref_dist[i] = (i == 0) ? 0 : INF;
  endtask

  task automatic preload(input logic [IW-1:0] idx, input logic [VW-1:0] val);
    @(negedge clock);
    pre_req = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(negedge clock);
    pre_req = 1'b0;
    ref_dist[idx] = int'(val);
  endtask

  task automatic run_op(input logic [IW-1:0] src, input logic [IW-1:0] dst,
                        input logic [VW-1:0] w, input bit again);
    int du, dv, sum, wr_cnt, done_cnt, done_cyc;
    bit imp, upd, busy1;
    logic [IW-1:0] idx1, idx3, wr_idx;
    logic [VW-1:0] wr_val, bus_u, bus_v;
    du  = ref_dist[src];
    dv  = ref_dist[dst];
    sum = du + int'(w);
    imp = (du != INF) && (sum < INF) && (sum < dv);
    wr_cnt = 0; done_cnt = 0; done_cyc = -1; upd = 1'b0; busy1 = 1'b0;
    idx1 = '0; idx3 = '0; wr_idx = '0; wr_val = '0; bus_u = '0; bus_v = '0;

    @(negedge clock);
    req.start   = 1'b1;
    req.src_idx = src;
    req.dst_idx = dst;
    req.weight  = w;
    @(posedge clock);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clock);
      if (cyc == 1) req.start = 1'b0;
      if (cyc == 2 && again) req.start = 1'b1;
      if (cyc == 3) req.start = 1'b0;
      if (cyc == 1) begin idx1 = store_index; busy1 = req.busy; end
      if (cyc == 2) bus_u = store_value;
      if (cyc == 3) idx3 = store_index;
      if (cyc == 4) bus_v = store_value;
      if (store_set_en) begin
        wr_cnt++;
        wr_idx = store_index;
        wr_val = store_value;
      end
      if (req.done) begin
        done_cnt++;
        done_cyc = cyc;
        upd = req.updated;
      end
    end
    if (imp) ref_dist[dst] = sum;

    check("busy_c1",   32'(busy1), 32'd1);
    check("rd_u_idx",  32'(idx1), 32'(src));
    check("rd_v_idx",  32'(idx3), 32'(dst));
    check("bus_du",    32'(bus_u), 32'(du));
    check("bus_dv",    32'(bus_v), 32'(dv));
    check("done_cnt",  done_cnt, 1);
    check("done_cyc",  done_cyc, imp ? 6 + WC : 6);
    check("updated",   32'(upd), 32'(imp));
    check("wr_cycles", wr_cnt, imp ? WC : 0);
    if (imp) begin
      check("wr_idx", 32'(wr_idx), 32'(dst));
      check("wr_val", 32'(wr_val), 32'(sum));
    end
    check("dist_dst",  32'(mem[dst]), ref_dist[dst]);
    check("busy_end",  32'(req.busy), 32'd0);
  endtask

  initial begin
    req.start = 1'b0; req.src_idx = '0; req.dst_idx = '0; req.weight = '0;

    // Reset held for two cycles while the store is initialised.
    clear_store();
    check("rst_set_en", 32'(store_set_en), 32'd0);
    check("rst_busy",   32'(req.busy), 32'd0);
    check("rst_done",   32'(req.done), 32'd0);
    check("rst_upd",    32'(req.updated), 32'd0);
    check("rst_index",  32'(store_index), 32'd0);
    check("rst_bus",    32'(store_value), 32'(rd_q));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("idle_busy", 32'(req.busy), 32'd0);
      check("idle_done", 32'(req.done), 32'd0);
    end

    run_op(4'd0, 4'd3, 8'd7, 1'b0);
`ifdef RELAX_STATS_EN
    check("cnt_s2", 32'(update_count), 32'd1);
`endif
    run_op(4'd0, 4'd3, 8'd9, 1'b1);
`ifdef RELAX_STATS_EN
    check("cnt_s3", 32'(update_count), 32'd1);
`endif
    run_op(4'd5, 4'd3, 8'd1, 1'b0);
    run_op(4'd3, 4'd3, 8'd0, 1'b0);
    preload(4'd1, 8'(INF - 2));
    run_op(4'd1, 4'd4, 8'd5, 1'b0);
    run_op(4'd1, 4'd4, 8'd1, 1'b0);

    // Reset during the first write cycle.
    clear_store();
    @(negedge clock);
    req.start = 1'b1; req.src_idx = 4'd0; req.dst_idx = 4'd3; req.weight = 8'd7;
    @(posedge clock);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clock);
      if (cyc == 1) req.start = 1'b0;
    end
    check("wr_began", 32'(store_set_en), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_set_en", 32'(store_set_en), 32'd0);
    check("arst_bus",    32'(store_value), 32'(rd_q));
    check("arst_busy",   32'(req.busy), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("arst_done", 32'(req.done), 32'd0);
`ifdef RELAX_STATS_EN
      check("cnt_rst", 32'(update_count), 32'd0);
`endif
    end
    clear_store();
    reset = 1'b1;
    run_op(4'd0, 4'd3, 8'd7, 1'b0);
`ifdef RELAX_STATS_EN
    check("cnt_after", 32'(update_count), 32'd1);
`endif

    // Randomized relaxations over nodes 0..7.
    for (int i = 1; i < 8; i++)
      preload(IW'(i), ($urandom_range(0, 3) == 0) ? 8'(INF) : 8'($urandom_range(0, 200)));
    for (int n = 0; n < 40; n++) begin
      logic [IW-1:0] s, d;
      logic [VW-1:0] w;
      s = IW'($urandom_range(0, 7));
      d = IW'($urandom_range(0, 7));
      w = ($urandom_range(0, 3) == 0) ? VW'($urandom_range(0, INF)) : VW'($urandom_range(0, 30));
      run_op(s, d, w, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/dist_relax_ctrl.md
Name: dist_relax_ctrl

Overview:
- Initiator side of the DistanceStore read/write interface: performs one Dijkstra edge relaxation per `start`, i.e. dist[dst] = min(dist[dst], dist[src] + weight).
- Issues two reads and, when the path improves, one write over the shared store bus (`set_en`, `index`, bidirectional `value`).
- Sits between the edge-scan sequencer and DistanceStore; the store is the responder.

Parameters:
- MAX_NODES, `DEFAULT_MAX_NODES: node count; valid indices are 0..MAX_NODES-1.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH: width of node indices.
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH: width of distances and weights.
- WRITE_CYCLES, 2: cycles `store_set_en` is held high per write (store requires ≥2).

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  request pulse; sampled only in IDLE.
- src_idx  in  INDEX_WIDTH  node u; latched on accepted start.
- dst_idx  in  INDEX_WIDTH  node v; latched on accepted start.
- weight  in  VALUE_WIDTH  edge weight w(u,v); latched on accepted start.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse at end of operation.
- updated  out  1  valid with done: 1 = store was written.
- store_set_en  out  1  write enable to DistanceStore.
- store_index  out  INDEX_WIDTH  address to DistanceStore.
- store_value  inout  VALUE_WIDTH  driven only while store_set_en=1; otherwise high-Z and sampled as read data.

Behaviour:
- Reset (async, reset=0): state=IDLE; busy=0, done=0, updated=0, store_set_en=0, store_index=0, store_value=Z; latched operands=0. Release is synchronous to the next posedge.
- Read timing: the store returns data for `store_index` one full cycle after the index is presented. The controller captures at the end of the second cycle.
- FSM, one state per cycle unless noted:
  - IDLE: if start=1, latch operands and go to SET_U.
  - SET_U: index=src, go to CAP_U.
  - CAP_U: capture du, go to SET_V.
  - SET_V: index=dst, go to CAP_V.
  - CAP_V: capture dv, go to EVAL.
  - EVAL: compute sum = du + w in VALUE_WIDTH+1 bits.
    - improve = (du != `INFINITY) && (sum < `INFINITY) && (sum < dv).
    - If improve, go to WRITE; otherwise go to FIN.
  - WRITE: store_set_en=1, index=dst, value=sum[VALUE_WIDTH-1:0], held for WRITE_CYCLES cycles; then go to FIN.
  - FIN: done=1, updated=improve; go to IDLE.
- Latency, counting the start-sampling edge as cycle 0:
  - done is high in cycle 6 with no write.
  - done is high in cycle 6+WRITE_CYCLES with a write (8 by default).
- start while busy: ignored, not queued.
- src==dst: never improves, since sum ≥ du = dv; no write.
- Saturation: if du + w reaches or exceeds `INFINITY`, including carry-out, there is no update. `INFINITY` is never written.
- Out-of-range index (≥ MAX_NODES): forwarded unchanged; behaviour is the store's responsibility.
- Reset mid-operation: store_set_en drops and the bus goes Z immediately (asynchronously). No done pulse. A write in progress may or may not have committed.
- store_value is never driven in the same cycle the store drives it: set_en is low in every read state.

Optional Feature:
- Macro: RELAX_STATS_EN.
- Defined:
  - Adds output `update_count` [15:0].
  - Increments in FIN when updated=1.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset only.
- Undefined: port and counter absent; behaviour is otherwise identical.

Test Plan:
1. Bench uses a DistanceStore model: after reset dist[0]=0, all others `INFINITY`. Hold reset=0 for 2 cycles -> busy=0, done=0, store_set_en=0, store_value=Z; stays idle with start=0.
2. start, src=0, dst=3, w=7 -> reads idx 0 then 3; store_set_en high exactly 2 cycles with index=3, value=7; done+updated=1 in cycle 8; store readback dist[3]=7.
3. Then src=0, dst=3, w=9 -> no write (9≥7); done in cycle 6 with updated=0; dist[3] stays 7. Pulse start again at cycle 2 -> ignored, exactly one done.
4. src=5 (dist=`INFINITY`), dst=3, w=1 -> updated=0, store_set_en never asserted. src=3, dst=3, w=0 -> updated=0.
5. Preload dist[1]=`INFINITY`-2; src=1, dst=4, w=5 -> saturates, updated=0, dist[4] stays `INFINITY`. With w=1 -> sum=`INFINITY`-1, written, updated=1.
6. Assert reset during the first WRITE cycle -> store_set_en=0 and value=Z in the same timestep, busy=0, no done. After release, scenario 2 repeats correctly. With RELAX_STATS_EN defined: update_count=1 after scenario 2, unchanged after scenario 3, 0 after reset.
